// File: rtl/bsg_manycore_ruche_link_out_arbiter.sv
// Round-robin, credit-gated scheduler for one ruche link output direction.
// The winning single-flit packet is registered onto the long-haul link.
module bsg_manycore_ruche_link_out_arbiter #(
  parameter int width_p   = 32,
  parameter int num_in_p  = 3,
  parameter int credits_p = 4,
  localparam int credit_w_lp = $clog2(credits_p + 1),
  localparam int ptr_w_lp    = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [num_in_p-1:0]           v_i,
  input  logic [num_in_p*width_p-1:0]   data_i,
  output logic [num_in_p-1:0]           yumi_o,
  input  logic                          stall_i,
  output logic                          v_o,
  output logic [width_p-1:0]            data_o,
  input  logic                          credit_i,
  output logic [credit_w_lp-1:0]        credits_o,
  output logic                          error_o
);

  if (num_in_p < 2 || num_in_p > 8) begin : g_bad_num_in
    $error("num_in_p must be in 2..8");
  end
  if (credits_p < 1 || credits_p > 15) begin : g_bad_credits
    $error("credits_p must be in 1..15");
  end
  if (width_p < 1) begin : g_bad_width
    $error("width_p must be set to the link packet width");
  end

  localparam logic [credit_w_lp-1:0] credits_max_lp = credit_w_lp'(credits_p);

  logic [ptr_w_lp-1:0]    ptr_q, ptr_d;
  logic [credit_w_lp-1:0] credits_q, credits_d;
  logic                   error_q, error_d;
  logic                   v_q, v_d;
  logic [width_p-1:0]     data_q, data_d;

  logic                   grant;
  logic                   found;
  logic [ptr_w_lp-1:0]    win_idx;
  int                     cand;
  logic                   overflow;

  // Search upward from the source after the last winner, wrapping around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 1; k <= num_in_p; k++) begin
      cand = (int'(ptr_q) + k) % num_in_p;
      if (!found && v_i[ptr_w_lp'(cand)]) begin
        found   = 1'b1;
        win_idx = ptr_w_lp'(cand);
      end
    end
  end

  assign grant    = found & ~stall_i & ~reset_i & (credits_q != '0);
  assign yumi_o   = grant ? (num_in_p'(1) << win_idx) : '0;
  assign overflow = credit_i & ~grant & (credits_q == credits_max_lp);

  always_comb begin
    ptr_d     = ptr_q;
    credits_d = credits_q;
    error_d   = error_q;
    v_d       = grant;
    data_d    = data_q;
    if (grant) begin
      ptr_d  = win_idx;
      data_d = data_i[win_idx*width_p +: width_p];
    end
    if (grant && !credit_i) begin
      credits_d = credits_q - credit_w_lp'(1);
    end else if (credit_i && !grant) begin
      if (overflow) error_d = 1'b1;
      else          credits_d = credits_q + credit_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q     <= ptr_w_lp'(num_in_p - 1);
      credits_q <= credits_max_lp;
      error_q   <= 1'b0;
      v_q       <= 1'b0;
      data_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      error_q   <= error_d;
      v_q       <= v_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!overflow)
        else $warning("credit returned while credit counter already full");
    end
  end

  assign v_o       = v_q;
  assign data_o    = data_q;
  assign credits_o = credits_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_bsg_manycore_ruche_link_out_arbiter.sv
// Randomized + directed bench with a queue scoreboard for link output packets.
module tb_bsg_manycore_ruche_link_out_arbiter;
  localparam int W = 16;
  localparam int N = 3;
  localparam int C = 4;
  localparam int CW = $clog2(C + 1);

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   yumi_o;
  logic           stall_i;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           credit_i;
  logic [CW-1:0]  credits_o;
  logic           error_o;

  bsg_manycore_ruche_link_out_arbiter #(
    .width_p(W), .num_in_p(N), .credits_p(C)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
    .yumi_o(yumi_o), .stall_i(stall_i), .v_o(v_o), .data_o(data_o),
    .credit_i(credit_i), .credits_o(credits_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  int           n_vec = 0;
  int           n_bad = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;

  int           m_cred;
  int           m_ptr;
  bit           m_err;
  logic [W-1:0] m_data;
  logic [W-1:0] src_data[N];
  logic [N-1:0] last_grant;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: link output must match the scoreboard in timing and content.
  always @(negedge clk_i) begin
    exp_t e;
    bit   exp_v;
    if (mon_en) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        n_vec++; n_bad++;
        $display("FAIL link_stale cyc=%0d due=%0d data never delivered", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
      exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
      n_vec++;
      if (v_o !== exp_v) begin
        n_bad++;
        $display("FAIL link_valid cyc=%0d got=%b exp=%b", cyc, v_o, exp_v);
      end
      if (exp_v) begin
        e = sbq.pop_front();
        if (v_o === 1'b1) begin
          n_vec++;
          if (data_o !== e.data) begin
            n_bad++;
            $display("FAIL link_data cyc=%0d got=%0h exp=%0h", cyc, data_o, e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, expv);
    end
  endtask

  // One clock cycle: drive, check combinational/state outputs, advance the model.
  task automatic step(input logic [N-1:0] v, input bit stall, input bit cr, input bit rst);
    int           win;
    bit           g;
    logic [N-1:0] ey;
    v_i = v; stall_i = stall; credit_i = cr; reset_i = rst;
    for (int i = 0; i < N; i++) data_i[i*W +: W] = src_data[i];
    @(negedge clk_i);
    g   = !rst && (v != '0) && !stall && (m_cred > 0);
    win = -1;
    if (g) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (win < 0 && v[c]) win = c;
      end
    end
    ey = g ? (N'(1) << win) : '0;
    chk("yumi", 32'(yumi_o), 32'(ey));
    chk("credits", 32'(credits_o), 32'(m_cred));
    chk("error", 32'(error_o), 32'(m_err));
    chk("data_hold", 32'(data_o), 32'(m_data));
    last_grant = ey;
    if (rst) begin
      m_cred = C; m_err = 1'b0; m_ptr = N - 1; m_data = '0;
    end else begin
      if (g) begin
        sbq.push_back(exp_t'{src_data[win], cyc + 1});
        m_data = src_data[win];
        m_ptr  = win;
        m_cred--;
      end
      if (cr) begin
        if (m_cred == C) m_err = 1'b1;
        else             m_cred++;
      end
    end
    @(posedge clk_i); #1;
    for (int i = 0; i < N; i++) if (ey[i]) src_data[i] = W'($urandom);
  endtask

  initial begin
    logic [N-1:0] rv;
    bit           st, cr, rs;
    reset_i = 1'b1; v_i = '0; stall_i = 1'b0; credit_i = 1'b0; data_i = '0;
    for (int i = 0; i < N; i++) src_data[i] = W'($urandom);
    repeat (2) @(posedge clk_i);
    #1;
    m_cred = C; m_err = 1'b0; m_ptr = N - 1; m_data = '0; last_grant = '0;
    mon_en = 1'b1;
    step('0, 0, 0, 1);
    step('0, 0, 0, 0);

    // round robin from source 0 until credits run out
    repeat (6) step(3'b111, 0, 0, 0);
    // credit at zero: grant only the following cycle
    step(3'b010, 0, 1, 0);
    step(3'b010, 0, 0, 0);
    step('0, 0, 0, 0);
    // steady state at count 2
    step('0, 0, 1, 0);
    step('0, 0, 1, 0);
    repeat (10) step(3'b001, 0, 1, 0);
    // stall with full credits, pointer must hold
    step('0, 0, 1, 0);
    step('0, 0, 1, 0);
    repeat (3) step(3'b100, 1, 0, 0);
    step(3'b100, 0, 0, 0);
    step(3'b101, 0, 0, 0);
    // overflow is sticky until reset
    step('0, 0, 1, 0);
    step('0, 0, 1, 0);
    step('0, 0, 1, 0);
    repeat (4) step(3'b011, 0, 0, 0);
    step('0, 0, 0, 0);
    step('0, 0, 0, 1);
    step('0, 0, 0, 0);
    // reset with a packet pending and count 1
    repeat (3) step(3'b001, 0, 0, 0);
    step(3'b111, 0, 0, 1);
    step(3'b111, 0, 0, 0);
    step('0, 0, 0, 0);

    // randomized traffic obeying valid/yumi hold and legal credit returns
    rv = '0;
    repeat (400) begin
      for (int i = 0; i < N; i++) if (!rv[i]) rv[i] = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 7) == 0);
      cr = (m_cred < C) && ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 96) == 0);
      step(rv, st, cr, rs);
      rv = rv & ~last_grant;
    end
    repeat (3) step('0, 0, 0, 0);

    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
